// File: rtl/core_pkg.sv
// Shared definitions for the memory stage: funct3 access encodings and FSM states.
package core_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a raw load word and sign/zero-extends it.
module load_align
    import core_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (lane)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            F3_W:    data = rdata;
            default: data = 32'd0;
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Pipeline stage 4: issues loads/stores to a variable-latency data memory,
// aligns load data, builds store strobes and stalls upstream while busy.
module stage_memory
    import core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_alu_out,
    input  logic [31:0] in_mem_data,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    input  logic        in_mem_read,
    input  logic        in_mem_write,
    input  logic        in_mem_to_reg,
    input  logic        in_write_enable,
    output logic        out_stall,
    output logic        out_req_valid,
    input  logic        in_req_ready,
    output logic [31:0] out_req_addr,
    output logic        out_req_write,
    output logic [31:0] out_req_wdata,
    output logic [3:0]  out_req_wstrb,
    input  logic        in_resp_valid,
    input  logic [31:0] in_resp_rdata,
    output logic        out_valid,
    output logic [31:0] out_alu_out,
    output logic [31:0] out_load_data,
    output logic [4:0]  out_rd,
    output logic        out_mem_to_reg,
    output logic        out_write_enable,
    output logic        out_fault
);

    localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

    mem_state_t  state;
    logic [31:0] cap_addr;
    logic [2:0]  cap_funct3;
    logic [4:0]  cap_rd;
    logic        cap_load;
    logic        cap_mem_to_reg;
    logic        cap_we;
    logic [31:0] tmo_cnt;

    logic        is_mem;
    logic        misaligned;
    logic        illegal;
    logic [31:0] st_wdata;
    logic [3:0]  st_wstrb;
    logic [31:0] aligned_data;

    assign out_stall     = (state != IDLE);
    assign out_req_valid = (state == REQ);
    assign out_req_addr  = {cap_addr[31:2], 2'b00};
    assign is_mem        = in_mem_read | in_mem_write;

    // A load takes precedence when both read and write are flagged.
    always_comb begin
        misaligned = 1'b0;
        case (in_funct3[1:0])
            2'b01:   misaligned = in_alu_out[0];
            2'b10:   misaligned = |in_alu_out[1:0];
            default: misaligned = 1'b0;
        endcase
        if (in_mem_read)
            illegal = (in_funct3 == 3'b011) || (in_funct3 == 3'b110) || (in_funct3 == 3'b111);
        else
            illegal = (in_funct3 != F3_B) && (in_funct3 != F3_H) && (in_funct3 != F3_W);
    end

    always_comb begin
        st_wdata = in_mem_data;
        st_wstrb = 4'b1111;
        case (in_funct3)
            F3_B: begin
                st_wdata = {4{in_mem_data[7:0]}};
                st_wstrb = 4'b0001 << in_alu_out[1:0];
            end
            F3_H: begin
                st_wdata = {2{in_mem_data[15:0]}};
                st_wstrb = 4'b0011 << {in_alu_out[1], 1'b0};
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .funct3 (cap_funct3),
        .lane   (cap_addr[1:0]),
        .rdata  (in_resp_rdata),
        .data   (aligned_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            cap_addr         <= 32'd0;
            cap_funct3       <= 3'd0;
            cap_rd           <= 5'd0;
            cap_load         <= 1'b0;
            cap_mem_to_reg   <= 1'b0;
            cap_we           <= 1'b0;
            tmo_cnt          <= 32'd0;
            out_req_write    <= 1'b0;
            out_req_wdata    <= 32'd0;
            out_req_wstrb    <= 4'd0;
            out_valid        <= 1'b0;
            out_alu_out      <= 32'd0;
            out_load_data    <= 32'd0;
            out_rd           <= 5'd0;
            out_mem_to_reg   <= 1'b0;
            out_write_enable <= 1'b0;
            out_fault        <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid && (!is_mem || misaligned || illegal)) begin
                        out_valid        <= 1'b1;
                        out_alu_out      <= in_alu_out;
                        out_load_data    <= 32'd0;
                        out_rd           <= in_rd;
                        out_mem_to_reg   <= in_mem_to_reg;
                        out_write_enable <= in_write_enable & ~is_mem;
                        out_fault        <= is_mem;
                    end else if (in_valid) begin
                        cap_addr       <= in_alu_out;
                        cap_funct3     <= in_funct3;
                        cap_rd         <= in_rd;
                        cap_load       <= in_mem_read;
                        cap_mem_to_reg <= in_mem_to_reg;
                        cap_we         <= in_write_enable;
                        out_req_write  <= ~in_mem_read;
                        out_req_wdata  <= in_mem_read ? 32'd0 : st_wdata;
                        out_req_wstrb  <= in_mem_read ? 4'd0 : st_wstrb;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    if (in_req_ready) begin
                        tmo_cnt <= 32'd0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (in_resp_valid) begin
                        out_valid        <= 1'b1;
                        out_alu_out      <= cap_addr;
                        out_load_data    <= cap_load ? aligned_data : 32'd0;
                        out_rd           <= cap_rd;
                        out_mem_to_reg   <= cap_mem_to_reg;
                        out_write_enable <= cap_we;
                        out_fault        <= 1'b0;
                        state            <= IDLE;
                    end else if ((TMO_LIMIT != 32'd0) && (tmo_cnt + 32'd1 == TMO_LIMIT)) begin
                        out_valid        <= 1'b1;
                        out_alu_out      <= cap_addr;
                        out_load_data    <= 32'd0;
                        out_rd           <= cap_rd;
                        out_mem_to_reg   <= cap_mem_to_reg;
                        out_write_enable <= 1'b0;
                        out_fault        <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
// Scenario bench for stage_memory with a scoreboard queue of expected writeback results.
module tb_stage_memory;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_alu_out;
    logic [31:0] in_mem_data;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        in_mem_read;
    logic        in_mem_write;
    logic        in_mem_to_reg;
    logic        in_write_enable;
    logic        out_stall;
    logic        out_req_valid;
    logic        in_req_ready;
    logic [31:0] out_req_addr;
    logic        out_req_write;
    logic [31:0] out_req_wdata;
    logic [3:0]  out_req_wstrb;
    logic        in_resp_valid;
    logic [31:0] in_resp_rdata;
    logic        out_valid;
    logic [31:0] out_alu_out;
    logic [31:0] out_load_data;
    logic [4:0]  out_rd;
    logic        out_mem_to_reg;
    logic        out_write_enable;
    logic        out_fault;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] ld;
        logic [4:0]  rd;
        logic        m2r;
        logic        we;
        logic        fault;
    } res_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic        rd_en;
        logic        wr_en;
        logic [31:0] rdata;
        logic [31:0] ld;
        logic [3:0]  strb;
        logic [31:0] rep;
    } op_t;

    res_t exp_q[$];
    res_t e;
    op_t  ops[8];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    stage_memory #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_alu_out       (in_alu_out),
        .in_mem_data      (in_mem_data),
        .in_funct3        (in_funct3),
        .in_rd            (in_rd),
        .in_mem_read      (in_mem_read),
        .in_mem_write     (in_mem_write),
        .in_mem_to_reg    (in_mem_to_reg),
        .in_write_enable  (in_write_enable),
        .out_stall        (out_stall),
        .out_req_valid    (out_req_valid),
        .in_req_ready     (in_req_ready),
        .out_req_addr     (out_req_addr),
        .out_req_write    (out_req_write),
        .out_req_wdata    (out_req_wdata),
        .out_req_wstrb    (out_req_wstrb),
        .in_resp_valid    (in_resp_valid),
        .in_resp_rdata    (in_resp_rdata),
        .out_valid        (out_valid),
        .out_alu_out      (out_alu_out),
        .out_load_data    (out_load_data),
        .out_rd           (out_rd),
        .out_mem_to_reg   (out_mem_to_reg),
        .out_write_enable (out_write_enable),
        .out_fault        (out_fault)
    );

    function automatic res_t observed();
        return res_t'({out_alu_out, out_load_data, out_rd, out_mem_to_reg, out_write_enable, out_fault});
    endfunction

    task automatic idle_inputs();
        in_valid        = 1'b0;
        in_alu_out      = 32'd0;
        in_mem_data     = 32'd0;
        in_funct3       = 3'd0;
        in_rd           = 5'd0;
        in_mem_read     = 1'b0;
        in_mem_write    = 1'b0;
        in_mem_to_reg   = 1'b0;
        in_write_enable = 1'b0;
        in_req_ready    = 1'b0;
        in_resp_valid   = 1'b0;
        in_resp_rdata   = 32'd0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({out_valid, out_stall, out_req_valid, out_fault, out_write_enable} !== 5'b0)
            $display("FAIL reset_ctrl: got %b required 00000",
                     {out_valid, out_stall, out_req_valid, out_fault, out_write_enable});
        else pass_cnt++;
        total_cnt++;
        if (out_alu_out !== 32'd0) $display("FAIL reset_alu: got %h required 0", out_alu_out);
        else pass_cnt++;
        total_cnt++;
        if (out_req_addr !== 32'd0) $display("FAIL reset_req_addr: got %h required 0", out_req_addr);
        else pass_cnt++;
        reset = 1'b0;
    endtask

    task automatic test_passthrough();
        @(negedge clk);
        in_valid = 1'b1; in_alu_out = 32'h1234; in_rd = 5'd5; in_write_enable = 1'b1;
        exp_q.push_back('{32'h1234, 32'd0, 5'd5, 1'b0, 1'b1, 1'b0});
        total_cnt++;
        if (out_stall !== 1'b0) $display("FAIL pass_stall_in: got %b required 0", out_stall);
        else pass_cnt++;
        @(negedge clk);
        idle_inputs();
        total_cnt++;
        if (out_stall !== 1'b0) $display("FAIL pass_stall_out: got %b required 0", out_stall);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL pass_valid: got %b required 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL pass_result: got result with no expected entry");
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL pass_result: got %h required %h", observed(), e);
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL pass_pulse: got %b required 0", out_valid);
        else pass_cnt++;
    endtask

    task automatic test_lb();
        @(negedge clk);
        in_valid = 1'b1; in_alu_out = 32'h103; in_funct3 = 3'b000; in_mem_read = 1'b1;
        in_mem_to_reg = 1'b1; in_write_enable = 1'b1; in_rd = 5'd7; in_req_ready = 1'b1;
        exp_q.push_back('{32'h103, 32'hFFFF_FF80, 5'd7, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        idle_inputs();
        in_req_ready = 1'b1;
        total_cnt++;
        if ({out_req_valid, out_req_write, out_stall} !== 3'b101)
            $display("FAIL lb_req_ctrl: got %b required 101", {out_req_valid, out_req_write, out_stall});
        else pass_cnt++;
        total_cnt++;
        if (out_req_addr !== 32'h100) $display("FAIL lb_req_addr: got %h required 00000100", out_req_addr);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({out_req_valid, out_stall, out_valid} !== 3'b010)
            $display("FAIL lb_wait1: got %b required 010", {out_req_valid, out_stall, out_valid});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({out_stall, out_valid} !== 2'b10)
            $display("FAIL lb_wait2: got %b required 10", {out_stall, out_valid});
        else pass_cnt++;
        in_resp_valid = 1'b1; in_resp_rdata = 32'h80FF_0000;
        @(negedge clk);
        in_resp_valid = 1'b0;
        total_cnt++;
        if ({out_stall, out_valid} !== 2'b01)
            $display("FAIL lb_done: got %b required 01", {out_stall, out_valid});
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL lb_result: got result with no expected entry");
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL lb_result: got %h required %h", observed(), e);
            else pass_cnt++;
        end
        in_req_ready = 1'b0;
    endtask

    task automatic test_sh();
        @(negedge clk);
        in_valid = 1'b1; in_alu_out = 32'h202; in_mem_data = 32'h0000_ABCD;
        in_funct3 = 3'b001; in_mem_write = 1'b1; in_rd = 5'd0;
        exp_q.push_back('{32'h202, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if ({out_req_valid, out_req_write, out_req_wstrb} !== 6'b11_1100)
                $display("FAIL sh_req_ctrl[%0d]: got %b required 111100", i,
                         {out_req_valid, out_req_write, out_req_wstrb});
            else pass_cnt++;
            total_cnt++;
            if ({out_req_addr, out_req_wdata} !== {32'h200, 32'hABCD_ABCD})
                $display("FAIL sh_req_data[%0d]: got %h/%h required 00000200/abcdabcd", i,
                         out_req_addr, out_req_wdata);
            else pass_cnt++;
            if (i < 2) @(negedge clk);
        end
        @(negedge clk);
        in_req_ready = 1'b1;
        @(negedge clk);
        in_req_ready = 1'b0;
        total_cnt++;
        if ({out_req_valid, out_stall, out_valid} !== 3'b010)
            $display("FAIL sh_wait: got %b required 010", {out_req_valid, out_stall, out_valid});
        else pass_cnt++;
        in_resp_valid = 1'b1;
        @(negedge clk);
        in_resp_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL sh_valid: got %b required 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0) $display("FAIL sh_result: got result with no expected entry");
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL sh_result: got %h required %h", observed(), e);
            else pass_cnt++;
        end
    endtask

    task automatic test_faults();
        logic [31:0] addrs [3];
        logic [2:0]  f3s   [3];
        logic        loads [3];
        addrs = '{32'h301, 32'h305, 32'h300};
        f3s   = '{3'b010, 3'b001, 3'b011};
        loads = '{1'b1, 1'b1, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_alu_out = addrs[i]; in_funct3 = f3s[i];
            in_mem_read = loads[i]; in_mem_write = ~loads[i]; in_mem_to_reg = loads[i];
            in_write_enable = 1'b1; in_rd = 5'(9 + i);
            exp_q.push_back('{addrs[i], 32'd0, 5'(9 + i), loads[i], 1'b0, 1'b1});
            @(negedge clk);
            idle_inputs();
            total_cnt++;
            if ({out_req_valid, out_stall, out_valid} !== 3'b001)
                $display("FAIL fault_ctrl[%0d]: got %b required 001", i,
                         {out_req_valid, out_stall, out_valid});
            else pass_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL fault_result[%0d]: got result with no expected entry", i);
            else begin
                e = exp_q.pop_front();
                if (observed() !== e) $display("FAIL fault_result[%0d]: got %h required %h", i, observed(), e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        ops[0] = '{32'h101, 32'd0, 3'b100, 1'b1, 1'b0, 32'h1234_5678, 32'h0000_0056, 4'h0, 32'd0};
        ops[1] = '{32'h106, 32'd0, 3'b001, 1'b1, 1'b0, 32'h8001_7FFF, 32'hFFFF_8001, 4'h0, 32'd0};
        ops[2] = '{32'h106, 32'd0, 3'b101, 1'b1, 1'b0, 32'h8001_7FFF, 32'h0000_8001, 4'h0, 32'd0};
        ops[3] = '{32'h108, 32'd0, 3'b010, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h0, 32'd0};
        ops[4] = '{32'h10A, 32'h0000_00A5, 3'b000, 1'b0, 1'b1, 32'h0, 32'd0, 4'b0100, 32'hA5A5_A5A5};
        ops[5] = '{32'h10C, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 32'h0, 32'd0, 4'b1111, 32'hCAFE_F00D};
        ops[6] = '{32'h110, 32'h1111_1111, 3'b000, 1'b1, 1'b1, 32'h0000_007F, 32'h0000_007F, 4'h0, 32'd0};
        ops[7] = '{32'h112, 32'd0, 3'b000, 1'b1, 1'b0, 32'h00C3_0000, 32'hFFFF_FFC3, 4'h0, 32'd0};
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_alu_out = ops[i].addr; in_mem_data = ops[i].wdata;
            in_funct3 = ops[i].f3; in_mem_read = ops[i].rd_en; in_mem_write = ops[i].wr_en;
            in_mem_to_reg = ops[i].rd_en; in_write_enable = 1'b1; in_rd = 5'(10 + i);
            in_req_ready = 1'b1;
            exp_q.push_back('{ops[i].addr, ops[i].ld, 5'(10 + i), ops[i].rd_en, 1'b1, 1'b0});
            @(negedge clk);
            idle_inputs();
            in_req_ready = 1'b1;
            total_cnt++;
            if ({out_req_valid, out_req_write, out_req_addr} !== {1'b1, ~ops[i].rd_en, ops[i].addr[31:2], 2'b00})
                $display("FAIL b2b_req[%0d]: got %b/%b/%h required 1/%b/%h", i, out_req_valid,
                         out_req_write, out_req_addr, ~ops[i].rd_en, {ops[i].addr[31:2], 2'b00});
            else pass_cnt++;
            if (!ops[i].rd_en) begin
                total_cnt++;
                if ({out_req_wstrb, out_req_wdata} !== {ops[i].strb, ops[i].rep})
                    $display("FAIL b2b_store[%0d]: got %b/%h required %b/%h", i, out_req_wstrb,
                             out_req_wdata, ops[i].strb, ops[i].rep);
                else pass_cnt++;
            end
            @(negedge clk);
            in_resp_valid = 1'b1; in_resp_rdata = ops[i].rdata;
            @(negedge clk);
            in_resp_valid = 1'b0;
            total_cnt++;
            if ({out_valid, out_stall} !== 2'b10)
                $display("FAIL b2b_valid[%0d]: got %b required 10", i, {out_valid, out_stall});
            else pass_cnt++;
            total_cnt++;
            if (exp_q.size() == 0) $display("FAIL b2b_result[%0d]: got result with no expected entry", i);
            else begin
                e = exp_q.pop_front();
                if (observed() !== e) $display("FAIL b2b_result[%0d]: got %h required %h", i, observed(), e);
                else pass_cnt++;
            end
        end
        in_req_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int cycles;
        @(negedge clk);
        in_valid = 1'b1; in_alu_out = 32'h400; in_funct3 = 3'b010; in_mem_read = 1'b1;
        in_mem_to_reg = 1'b1; in_write_enable = 1'b1; in_rd = 5'd3; in_req_ready = 1'b1;
        exp_q.push_back('{32'h400, 32'd0, 5'd3, 1'b1, 1'b0, 1'b1});
        cycles = 0;
        for (int i = 1; i <= 20 && cycles == 0; i++) begin
            @(negedge clk);
            if (i == 1) begin
                idle_inputs();
                in_req_ready = 1'b1;
            end
            if (out_valid === 1'b1) cycles = i;
        end
        in_req_ready = 1'b0;
        total_cnt++;
        if (cycles != 6) $display("FAIL tmo_latency: got %0d cycles required 6", cycles);
        else pass_cnt++;
        total_cnt++;
        if (exp_q.size() == 0 || cycles == 0) $display("FAIL tmo_result: no result observed");
        else begin
            e = exp_q.pop_front();
            if (observed() !== e) $display("FAIL tmo_result: got %h required %h", observed(), e);
            else pass_cnt++;
        end
        in_resp_valid = 1'b1; in_resp_rdata = 32'h5555_5555;
        @(negedge clk);
        in_resp_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_stall} !== 2'b00)
            $display("FAIL tmo_stray_resp: got %b required 00", {out_valid, out_stall});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        in_valid = 1'b1; in_alu_out = 32'h500; in_funct3 = 3'b010; in_mem_read = 1'b1;
        in_write_enable = 1'b1; in_rd = 5'd4; in_req_ready = 1'b1;
        @(negedge clk);
        idle_inputs();
        in_req_ready = 1'b1;
        @(negedge clk);
        in_req_ready = 1'b0;
        total_cnt++;
        if ({out_stall, out_req_valid} !== 2'b10)
            $display("FAIL rstmid_wait: got %b required 10", {out_stall, out_req_valid});
        else pass_cnt++;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({out_stall, out_req_valid, out_valid, out_fault} !== 4'b0000)
            $display("FAIL rstmid_ctrl: got %b required 0000", {out_stall, out_req_valid, out_valid, out_fault});
        else pass_cnt++;
        total_cnt++;
        if ({out_alu_out, out_rd, out_req_addr} !== 69'd0)
            $display("FAIL rstmid_data: got %h/%h/%h required 0", out_alu_out, out_rd, out_req_addr);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        in_resp_valid = 1'b1; in_resp_rdata = 32'h7777_7777;
        @(negedge clk);
        in_resp_valid = 1'b0;
        total_cnt++;
        if ({out_valid, out_stall, out_load_data} !== 34'd0)
            $display("FAIL rstmid_late_resp: got %b/%b/%h required 0/0/0", out_valid, out_stall, out_load_data);
        else pass_cnt++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_passthrough();
        test_lb();
        test_sh();
        test_faults();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage 4, between stage_execute and writeback.
- Consumes the execute stage's ALU result, store data and memory control bits. Issues load/store requests to a variable-latency data memory over a valid/ready request channel and a valid-only response channel.
- Aligns and sign/zero-extends load data, generates store byte strobes, and stalls the upstream pipeline while an access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 256, max cycles spent in WAIT before a bus fault is reported; 0 disables the timeout.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream instruction present
- in_alu_out  input  32  effective address, or ALU result for non-memory ops
- in_mem_data  input  32  store data (rs2)
- in_funct3  input  3  access size/sign
- in_rd  input  5  destination register
- in_mem_read  input  1  load
- in_mem_write  input  1  store
- in_mem_to_reg  input  1  writeback selects load data
- in_write_enable  input  1  register write
- out_stall  output  1  upstream must hold its inputs
- out_req_valid  output  1  memory request valid
- in_req_ready  input  1  memory accepts request
- out_req_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- out_req_write  output  1  1 = store
- out_req_wdata  output  32  lane-replicated store data
- out_req_wstrb  output  4  byte strobes
- in_resp_valid  input  1  response/ack (loads and stores)
- in_resp_rdata  input  32  raw load word
- out_valid  output  1  result valid to writeback
- out_alu_out  output  32  passed ALU result
- out_load_data  output  32  extended load data
- out_rd  output  5  passed rd
- out_mem_to_reg  output  1  passed
- out_write_enable  output  1  passed; forced 0 on fault
- out_fault  output  1  misaligned, illegal funct3, or timeout

Behaviour:
- Reset: state=IDLE. All outputs 0, timeout counter 0. Reset asserted mid-access aborts the access. Any later in_resp_valid is ignored, since responses are accepted only in WAIT.
- FSM states: IDLE, REQ, WAIT.
- out_stall = (state != IDLE).
- IDLE, in_valid, no mem op: all fields registered; out_valid=1 next cycle (1-cycle latency); state stays IDLE.
- IDLE, in_valid, mem op: capture all inputs.
  - If misaligned or illegal: out_valid=1, out_fault=1, out_write_enable=0 next cycle; no request issued; stay IDLE.
  - Otherwise go to REQ.
- Misalignment rules: halfword requires addr[0]=0; word requires addr[1:0]=0.
- Illegal funct3: load 011/110/111; store other than 000/001/010.
- in_mem_read and in_mem_write both set: treat as a load; the store is ignored.
- REQ: out_req_valid=1, request fields stable until in_req_ready. On the handshake go to WAIT and clear the counter.
- WAIT: out_req_valid=0.
  - in_resp_valid=1: register the result, out_valid=1 next cycle, go to IDLE.
  - Counter reaches TIMEOUT_CYCLES (when nonzero): out_valid=1, out_fault=1, out_write_enable=0, go to IDLE.
- in_resp_valid outside WAIT is ignored. Memory guarantees the response comes at least 1 cycle after the request handshake.
- out_valid is a 1-cycle pulse per instruction; the other outputs hold until the next result.
- Load extension uses lane = addr[1:0]:
  - LB (000) / LBU (100): byte lane = addr[1:0], sign/zero-extended.
  - LH (001) / LHU (101): half lane = addr[1], sign/zero-extended.
  - LW (010): word unchanged.
- Store encoding:
  - SB: wstrb = 0001 << addr[1:0]; wdata = byte replicated 4x.
  - SH: wstrb = 0011 << {addr[1],1'b0}; wdata = half replicated 2x.
  - SW: wstrb = 1111; wdata unchanged.
- For stores, out_load_data = 0.
- Minimum memory-op latency: in_valid to out_valid = 3 cycles, with req_ready and resp in the earliest cycles.

Decomposition:
- Shared package (core_pkg):
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - enum mem_state_t {IDLE, REQ, WAIT}.
- Sub-module load_align: combinational funct3 + addr[1:0] + rdata -> extended data.
- Store strobe/replication logic stays inline.

Test Plan:
- ALU passthrough: in_valid=1, no mem op, alu_out=0x1234, rd=5, we=1 -> next cycle out_valid=1, out_alu_out=0x1234, out_rd=5, stall never asserted.
- LB sign extension: addr=0x103, funct3=000, ready immediately, resp after 2 cycles with rdata=0x80FF_0000 -> out_load_data=0xFFFF_FF80, out_req_addr=0x100, stall high exactly while not IDLE.
- SH upper half: addr=0x202, data=0x0000_ABCD, funct3=001, ready held low 3 cycles -> req fields stable for those cycles, wstrb=1100, wdata=0xABCD_ABCD, out_valid after ack.
- Misaligned LW: addr=0x301 -> no out_req_valid, next cycle out_fault=1, out_write_enable=0.
- Timeout and late response: TIMEOUT_CYCLES=4, no response -> fault after 4 WAIT cycles. A subsequent stray in_resp_valid in IDLE -> no out_valid.
- Reset mid-operation: reset asserted in WAIT -> immediately state IDLE, out_stall=0, all outputs 0; a response one cycle after reset is ignored.
